// File: rtl/multi_zone_irrigation_controller_pkg.sv
// Shared types and helpers for the multi-zone irrigation controller.
package irrigation_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        WATER = 2'd1,
        CLEAN = 2'd2
    } irr_state_t;

    localparam int unsigned SPRINKLER_DRAIN = 2;
    localparam int unsigned DRIPPER_DRAIN   = 1;

    // A zone is usable only when exactly one watering mode is selected.
    function automatic logic zone_valid(input logic sprinkler, input logic dripper);
        return sprinkler ^ dripper;
    endfunction

endpackage

// File: rtl/multi_zone_irrigation_controller_zone_arbiter.sv
// Combinational round-robin search: first valid zone at or after a start index.
module zone_arbiter #(
    parameter int unsigned ZONES = 4,
    localparam int unsigned ZW = $clog2(ZONES)
) (
    input  logic [ZONES-1:0] valid,
    input  logic [ZW-1:0]    start,
    output logic [ZW-1:0]    index,
    output logic             none_valid
);

    int unsigned cand;

    always_comb begin
        index      = start;
        none_valid = 1'b1;
        cand       = 0;
        for (int unsigned k = 0; k < ZONES; k++) begin
            cand = (32'(start) + k) % ZONES;
            if (none_valid && valid[cand]) begin
                index      = ZW'(cand);
                none_valid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_zone_irrigation_controller.sv
// Multi-zone irrigation controller: tank level, round-robin zone dwell, fertilise/clean cycle.
// Optional fertiliser/clean feature is enabled by defining FERTILISER_EN.
module multi_zone_irrigation_controller
    import irrigation_pkg::*;
#(
    parameter int unsigned ZONES       = 4,
    parameter int unsigned LEVEL_W     = 3,
    parameter int unsigned LEVEL_MAX   = 7,
    parameter int unsigned LOW_LEVEL   = 1,
    parameter int unsigned DWELL       = 3,
    parameter int unsigned CLEAN_TICKS = 2,
    localparam int unsigned ZW = $clog2(ZONES)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic [ZONES-1:0]   zone_sprinkler,
    input  logic [ZONES-1:0]   zone_dripper,
    input  logic               fertilise_request,
    output logic [ZONES-1:0]   valve,
    output logic               sprinkler_active,
    output logic               dripper_active,
    output logic               fertilising,
    output logic               cleaning,
    output logic [LEVEL_W-1:0] water_level,
    output logic [1:0]         state,
    output logic [ZW-1:0]      zone_index,
    output logic [ZONES-1:0]   input_error
);

`ifdef FERTILISER_EN
    localparam bit FERT_EN = 1'b1;
`else
    localparam bit FERT_EN = 1'b0;
`endif

    localparam int unsigned DW_W = $clog2(DWELL + 1);
    localparam int unsigned CW   = $clog2(CLEAN_TICKS + 1);

    irr_state_t         state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d, lvl_after;
    logic [ZW-1:0]      zone_q, zone_d, zone_after;
    logic [DW_W-1:0]    dwell_q, dwell_d;
    logic [CW-1:0]      clean_q, clean_d;
    logic               pending_q, pending_d;
    logic               fert_q, fert_d, fert_end;
    logic               cleaning_d, spr_d, drip_d, dwell_end;
    logic [ZONES-1:0]   valve_d, zone_ok;
    logic [ZW-1:0]      here_idx, next_idx;
    logic               here_none, unused_next_none;
    int unsigned        drain;

    assign input_error = zone_sprinkler & zone_dripper;

    always_comb begin
        zone_ok = '0;
        for (int unsigned i = 0; i < ZONES; i++) begin
            zone_ok[i] = zone_valid(zone_sprinkler[i], zone_dripper[i]);
        end
    end

    assign zone_after = (zone_q == ZW'(ZONES - 1)) ? '0 : zone_q + ZW'(1);

    zone_arbiter #(.ZONES(ZONES)) u_arb_here (
        .valid      (zone_ok),
        .start      (zone_q),
        .index      (here_idx),
        .none_valid (here_none)
    );

    // Searching from the zone after the current one wraps back onto it if it is the only valid zone.
    zone_arbiter #(.ZONES(ZONES)) u_arb_next (
        .valid      (zone_ok),
        .start      (zone_after),
        .index      (next_idx),
        .none_valid (unused_next_none)
    );

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        zone_d    = zone_q;
        dwell_d   = dwell_q;
        clean_d   = '0;
        fert_end  = 1'b0;
        dwell_end = 1'b0;
        lvl_after = level_q;
        drain     = zone_sprinkler[zone_q] ? SPRINKLER_DRAIN : DRIPPER_DRAIN;

        case (state_q)
            FILL: begin
                dwell_d = '0;
                if (tick && level_q < LEVEL_W'(LEVEL_MAX)) begin
                    level_d = level_q + LEVEL_W'(1);
                end
                if (level_d == LEVEL_W'(LEVEL_MAX) && !here_none) begin
                    state_d = WATER;
                    zone_d  = here_idx;
                end
            end
            WATER: begin
                if (!zone_ok[zone_q]) begin
                    dwell_d  = '0;
                    fert_end = fert_q;
                    if (here_none) begin
                        state_d = FILL;
                    end else begin
                        zone_d = here_idx;
                    end
                end else if (tick) begin
                    lvl_after = (32'(level_q) >= drain) ? level_q - LEVEL_W'(drain) : '0;
                    level_d   = lvl_after;
                    dwell_end = (dwell_q == DW_W'(DWELL - 1));
                    if (dwell_end) begin
                        zone_d   = next_idx;
                        dwell_d  = '0;
                        fert_end = fert_q;
                    end else begin
                        dwell_d = dwell_q + DW_W'(1);
                    end
                    // Low level wins over dwell end but keeps the already-advanced zone.
                    if (lvl_after <= LEVEL_W'(LOW_LEVEL)) begin
                        dwell_d  = '0;
                        fert_end = fert_q;
                        state_d  = (FERT_EN && fert_q) ? CLEAN : FILL;
                    end
                end
            end
            CLEAN: begin
                clean_d = clean_q;
                if (tick) begin
                    if (clean_q == CW'(CLEAN_TICKS - 1)) begin
                        clean_d = '0;
                        if (level_q <= LEVEL_W'(LOW_LEVEL) || here_none) begin
                            state_d = FILL;
                        end else begin
                            state_d = WATER;
                            zone_d  = here_idx;
                        end
                    end else begin
                        clean_d = clean_q + CW'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase

        // A request while a fertilise cycle is already pending is absorbed.
        pending_d = FERT_EN && (pending_q ? !fert_end : fertilise_request);

        valve_d = '0;
        spr_d   = 1'b0;
        drip_d  = 1'b0;
        if (state_d == WATER) begin
            valve_d[zone_d] = 1'b1;
            spr_d           = zone_sprinkler[zone_d];
            drip_d          = zone_dripper[zone_d];
        end
        fert_d     = FERT_EN && (state_d == WATER) && pending_d && spr_d && !drip_d
                     && (level_d > LEVEL_W'(LOW_LEVEL));
        cleaning_d = FERT_EN && (state_d == CLEAN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= FILL;
            level_q          <= '0;
            zone_q           <= '0;
            dwell_q          <= '0;
            clean_q          <= '0;
            pending_q        <= 1'b0;
            fert_q           <= 1'b0;
            cleaning         <= 1'b0;
            valve            <= '0;
            sprinkler_active <= 1'b0;
            dripper_active   <= 1'b0;
        end else begin
            state_q          <= state_d;
            level_q          <= level_d;
            zone_q           <= zone_d;
            dwell_q          <= dwell_d;
            clean_q          <= clean_d;
            pending_q        <= pending_d;
            fert_q           <= fert_d;
            cleaning         <= cleaning_d;
            valve            <= valve_d;
            sprinkler_active <= spr_d;
            dripper_active   <= drip_d;
        end
    end

    assign state       = state_q;
    assign water_level = level_q;
    assign zone_index  = zone_q;
    assign fertilising = fert_q;

endmodule

// File: tb/tb_multi_zone_irrigation_controller.sv
// Directed self-checking bench for multi_zone_irrigation_controller (default parameters).
module tb_multi_zone_irrigation_controller;

`ifdef FERTILISER_EN
    localparam bit FEXP = 1'b1;
`else
    localparam bit FEXP = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] zone_sprinkler = '0;
    logic [3:0] zone_dripper = '0;
    logic       fertilise_request = 1'b0;
    logic [3:0] valve;
    logic       sprinkler_active, dripper_active, fertilising, cleaning;
    logic [2:0] water_level;
    logic [1:0] state;
    logic [1:0] zone_index;
    logic [3:0] input_error;

    int n_checks = 0;
    int n_fail   = 0;
    logic got;

    multi_zone_irrigation_controller #(
        .ZONES(4), .LEVEL_W(3), .LEVEL_MAX(7), .LOW_LEVEL(1), .DWELL(3), .CLEAN_TICKS(2)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .tick              (tick),
        .zone_sprinkler    (zone_sprinkler),
        .zone_dripper      (zone_dripper),
        .fertilise_request (fertilise_request),
        .valve             (valve),
        .sprinkler_active  (sprinkler_active),
        .dripper_active    (dripper_active),
        .fertilising       (fertilising),
        .cleaning          (cleaning),
        .water_level       (water_level),
        .state             (state),
        .zone_index        (zone_index),
        .input_error       (input_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic t);
        tick = t;
        @(posedge clock);
        #1;
        tick = 1'b0;
    endtask

    initial begin
        // Reset state
        zone_dripper = 4'b1111;
        step(1'b0);
        step(1'b0);
        reset = 1'b0;
        check("rst_level", water_level, 0);
        check("rst_state", state, 0);
        check("rst_zone", zone_index, 0);
        check("rst_valve", valve, 0);
        check("rst_flags", {sprinkler_active, dripper_active, fertilising, cleaning}, 0);

        // All dripper: fill 0..7 then water zone 0
        for (int i = 1; i <= 7; i++) begin
            step(1'b1);
            check("fill_level", water_level, i);
            check("fill_state", state, (i == 7) ? 1 : 0);
        end
        check("t1_zone", zone_index, 0);
        check("t1_valve", valve, 4'b0001);
        check("t1_drip", dripper_active, 1);

        // Only zone 0, sprinkler: 7->5->3->1 then FILL
        zone_sprinkler = 4'b0001;
        zone_dripper   = 4'b0000;
        step(1'b0);
        check("t2_spr", {sprinkler_active, dripper_active}, 2'b10);
        check("t2_valve", valve, 4'b0001);
        step(1'b1);
        check("t2_lvl5", water_level, 5);
        step(1'b1);
        check("t2_lvl3", water_level, 3);
        check("t2_st_w", state, 1);
        step(1'b1);
        check("t2_lvl1", water_level, 1);
        check("t2_state", state, 0);
        check("t2_valve0", valve, 0);
        check("t2_zone", zone_index, 0);

        // Zone 1 in error, zone 3 off: water 0 then 2
        zone_sprinkler = 4'b0010;
        zone_dripper   = 4'b0111;
        #1;
        check("t3_err", input_error, 4'b0010);
        for (int i = 2; i <= 7; i++) step(1'b1);
        check("t3_state", state, 1);
        check("t3_valve_z0", valve, 4'b0001);
        step(1'b1);
        check("t3_l6", water_level, 6);
        step(1'b1);
        step(1'b1);
        check("t3_l4", water_level, 4);
        check("t3_valve_z2", valve, 4'b0100);
        check("t3_zone2", zone_index, 2);
        step(1'b1);
        check("t3_l3", water_level, 3);
        step(1'b1);
        step(1'b1);
        check("t3_l1", water_level, 1);
        check("t3_fill", state, 0);
        check("t3_zone_wrap", zone_index, 0);
        check("t3_valve0", valve, 0);

        // Fertilise request during FILL, zone 0 sprinkler only
        zone_sprinkler    = 4'b0001;
        zone_dripper      = 4'b0000;
        fertilise_request = 1'b1;
        step(1'b0);
        fertilise_request = 1'b0;
        for (int i = 2; i <= 7; i++) step(1'b1);
        check("t4_water", state, 1);
        check("t4_fert_on", fertilising, FEXP);
        step(1'b1);
        step(1'b1);
        check("t4_fert_hold", fertilising, FEXP);
        step(1'b1);
        check("t4_lvl", water_level, 1);
        check("t4_state", state, FEXP ? 2 : 0);
        check("t4_clean", cleaning, FEXP);
        check("t4_fert_off", fertilising, 0);
        check("t4_valve", valve, 0);
        step(1'b1);
        check("t4_state2", state, FEXP ? 2 : 0);
        check("t4_lvl2", water_level, FEXP ? 1 : 2);
        step(1'b1);
        check("t4_state3", state, 0);
        check("t4_clean_off", cleaning, 0);
        check("t4_lvl3", water_level, FEXP ? 1 : 3);

        // Only zone 2 sprinkler; request coinciding with a tick
        zone_sprinkler    = 4'b0100;
        zone_dripper      = 4'b0000;
        fertilise_request = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1'b1);
            fertilise_request = 1'b0;
            if (state == 2'd1) got = 1'b1;
        end
        check("t5_reach_water", got, 1);
        check("t5_zone", zone_index, 2);
        check("t5_valve", valve, 4'b0100);
        check("t5_fert", fertilising, FEXP);
        step(1'b1);
        check("t5_lvl5", water_level, 5);

        // Asynchronous reset mid-WATER
        #1;
        reset = 1'b1;
        #1;
        check("t5_rst_valve", valve, 0);
        check("t5_rst_level", water_level, 0);
        check("t5_rst_state", state, 0);
        check("t5_rst_flags", {sprinkler_active, fertilising, cleaning}, 0);
        step(1'b0);
        reset = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1'b1);
            if (state == 2'd1) got = 1'b1;
        end
        check("t5_refill", got, 1);
        check("t5_lvl7", water_level, 7);
        check("t5_no_pending", fertilising, 0);
        check("t5_valve2", valve, 4'b0100);

        // Zone 2 goes invalid mid-dwell: move to zone 1 without a tick
        zone_dripper = 4'b0110;
        step(1'b0);
        check("t6_zone", zone_index, 1);
        check("t6_valve", valve, 4'b0010);
        check("t6_lvl", water_level, 7);
        check("t6_drip", dripper_active, 1);

        // No valid zone left: back to FILL
        zone_sprinkler = 4'b0000;
        zone_dripper   = 4'b0000;
        step(1'b0);
        check("t7_state", state, 0);
        check("t7_valve", valve, 0);
        check("t7_lvl", water_level, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
